hdmi_period_sequencer: RTL



---
 rtl/hdmi_period_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_period_sequencer.sv
// Per-pixel-clock TMDS lane scheduler: control tokens, HDMI preamble/guard band, or video.
// Optional feature macro: HDMI_PREAMBLE_EN (undefined builds a pure DVI sequencer).
module hdmi_period_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [9:0] sym0,
  output logic [9:0] sym1,
  output logic [9:0] sym2,
  output logic       vid_active
);

  localparam int unsigned Depth = 10;
  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;
`ifdef HDMI_PREAMBLE_EN
  localparam logic [9:0] GuardB = 10'b1011001100;
  localparam logic [9:0] GuardG = 10'b0100110011;
`endif

`ifdef HDMI_PREAMBLE_EN
  typedef enum logic [1:0] {StCtrl, StVideo, StPreamble, StGuard} state_e;
`else
  typedef enum logic [0:0] {StCtrl, StVideo} state_e;
`endif

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = Tok00;
      2'b01:   t = Tok01;
      2'b10:   t = Tok10;
      default: t = Tok11;
    endcase
    return t;
  endfunction

  // Returns {next disparity, 10-bit symbol} for one DVI 1.0 TMDS data character.
  function automatic logic [14:0] tmds_encode(input logic [7:0] d, input logic signed [4:0] disp);
    logic [8:0]        qm;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic signed [4:0] bal;
    logic signed [4:0] nxt;
    logic [9:0]        q;
    n1d = 4'd0;
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'd0, d[i]};
    qm = '0;
    qm[0] = d[0];
    if (n1d > 4'd4 || (n1d == 4'd4 && !d[0])) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    for (int i = 0; i < 8; i++) n1q = n1q + {3'd0, qm[i]};
    // ones minus zeros of qm[7:0]; wraps correctly modulo 32 for n1q = 8
    bal = $signed({n1q, 1'b0}) - 5'sd8;
    if (disp == 5'sd0 || bal == 5'sd0) begin
      q   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? disp + bal : disp - bal;
    end else if (disp[4] == bal[4]) begin
      q   = {1'b1, qm[8], ~qm[7:0]};
      nxt = disp + (qm[8] ? 5'sd2 : 5'sd0) - bal;
    end else begin
      q   = {1'b0, qm[8], qm[7:0]};
      nxt = disp - (qm[8] ? 5'sd0 : 5'sd2) + bal;
    end
    return {nxt, q};
  endfunction

  logic [26:0]       r_dl [Depth];
  state_e            r_state;
  state_e            w_state_nxt;
  logic [9:0]        r_sym0, r_sym1, r_sym2;
  logic              r_vid;
  logic signed [4:0] r_disp0, r_disp1, r_disp2;
  logic              w_d_de, w_d_hs, w_d_vs;
  logic [7:0]        w_d_red, w_d_green, w_d_blue;
  logic [14:0]       w_enc0, w_enc1, w_enc2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_dl[i] <= '0;
    end else begin
      r_dl[0] <= {de, hsync, vsync, red, green, blue};
      for (int i = 1; i < Depth; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  assign {w_d_de, w_d_hs, w_d_vs, w_d_red, w_d_green, w_d_blue} = r_dl[9];

`ifdef HDMI_PREAMBLE_EN
  logic [4:0] r_blank;
  logic [2:0] r_phase;
  logic       w_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if (de) begin
      r_blank <= '0;
    end else if (r_blank != 5'd31) begin
      r_blank <= r_blank + 5'd1;
    end
  end

  // Any de=1 after >= 22 blanks is necessarily a 0->1 edge.
  assign w_grant = de && (r_blank >= 5'd22);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= (w_state_nxt != r_state) ? 3'd0 : r_phase + 3'd1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StCtrl: begin
`ifdef HDMI_PREAMBLE_EN
        if (w_grant) w_state_nxt = StPreamble;
        else if (w_d_de) w_state_nxt = StVideo;
`else
        if (w_d_de) w_state_nxt = StVideo;
`endif
      end
      StVideo: begin
`ifdef HDMI_PREAMBLE_EN
        if (!w_d_de) w_state_nxt = w_grant ? StPreamble : StCtrl;
`else
        if (!w_d_de) w_state_nxt = StCtrl;
`endif
      end
`ifdef HDMI_PREAMBLE_EN
      StPreamble: begin
        if (w_d_de) w_state_nxt = StVideo;
        else if (r_phase == 3'd7) w_state_nxt = StGuard;
      end
      StGuard: begin
        if (w_d_de || r_phase == 3'd1) w_state_nxt = StVideo;
      end
`endif
      default: w_state_nxt = StCtrl;
    endcase
  end

  assign w_enc0 = tmds_encode(w_d_blue, r_disp0);
  assign w_enc1 = tmds_encode(w_d_green, r_disp1);
  assign w_enc2 = tmds_encode(w_d_red, r_disp2);

  // Symbols are chosen from the next state so they line up with the state's first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StCtrl;
      r_sym0  <= Tok00;
      r_sym1  <= Tok00;
      r_sym2  <= Tok00;
      r_vid   <= 1'b0;
      r_disp0 <= '0;
      r_disp1 <= '0;
      r_disp2 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vid   <= (w_state_nxt == StVideo);
      r_disp0 <= '0;
      r_disp1 <= '0;
      r_disp2 <= '0;
      case (w_state_nxt)
        StVideo: begin
          r_sym0  <= w_enc0[9:0];
          r_sym1  <= w_enc1[9:0];
          r_sym2  <= w_enc2[9:0];
          r_disp0 <= w_enc0[14:10];
          r_disp1 <= w_enc1[14:10];
          r_disp2 <= w_enc2[14:10];
        end
`ifdef HDMI_PREAMBLE_EN
        StPreamble: begin
          r_sym0 <= ctl_token({w_d_vs, w_d_hs});
          r_sym1 <= Tok01;
          r_sym2 <= Tok00;
        end
        StGuard: begin
          r_sym0 <= GuardB;
          r_sym1 <= GuardG;
          r_sym2 <= GuardB;
        end
`endif
        default: begin
          r_sym0 <= ctl_token({w_d_vs, w_d_hs});
          r_sym1 <= Tok00;
          r_sym2 <= Tok00;
        end
      endcase
    end
  end

  assign sym0       = r_sym0;
  assign sym1       = r_sym1;
  assign sym2       = r_sym2;
  assign vid_active = r_vid;

endmodule
